// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer: FSM encodings and clog2.
package mux_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority search: first requester after last_gnt, with wrap.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] last_gnt,
  output logic [SELW-1:0] gnt,
  output logic            gnt_vld
);

  int idx;

  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    // Offset 1..N so the previous winner is visited last.
    for (int i = 1; i <= N; i++) begin
      idx = (int'(last_gnt) + i) % N;
      if (!gnt_vld && req[idx]) begin
        gnt     = SELW'(idx);
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_stream.sv
// N-channel valid/ready stream mux, round-robin per packet, single registered output stage.
// Optional MUX_SEL_OVERRIDE_EN adds force_en/force_sel to steer the IDLE-state grant.
module mux_rr_stream
  import mux_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int W    = 8,
  localparam int SELW = (N > 1) ? clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_last,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic            out_last,
  output logic [SELW-1:0] out_sel,
`ifdef MUX_SEL_OVERRIDE_EN
  input  logic            force_en,
  input  logic [SELW-1:0] force_sel,
`endif
  input  logic            out_ready
);

  state_e          state_q, state_d;
  logic [SELW-1:0] gnt_q, gnt_d;
  logic [SELW-1:0] last_gnt_q, last_gnt_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic            out_last_q, out_last_d;
  logic [SELW-1:0] out_sel_q, out_sel_d;

  logic [SELW-1:0] arb_gnt;
  logic            arb_vld;
  logic            beat_ok;
  logic            accept;

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_arb (
    .req      (in_valid),
    .last_gnt (last_gnt_q),
    .gnt      (arb_gnt),
    .gnt_vld  (arb_vld)
  );

`ifdef MUX_SEL_OVERRIDE_EN
  logic force_hit;
  always_comb begin
    force_hit = 1'b0;
    if (int'(force_sel) < N) force_hit = in_valid[force_sel];
  end
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_gnt_d  = last_gnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    in_ready    = '0;
    beat_ok     = ~out_valid_q | out_ready;
    accept      = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
`ifdef MUX_SEL_OVERRIDE_EN
        if (force_en) begin
          if (force_hit) begin
            gnt_d   = force_sel;
            state_d = ST_BUSY;
          end
        end else if (arb_vld) begin
          gnt_d   = arb_gnt;
          state_d = ST_BUSY;
        end
`else
        if (arb_vld) begin
          gnt_d   = arb_gnt;
          state_d = ST_BUSY;
        end
`endif
      end
      ST_BUSY: begin
        in_ready[gnt_q] = beat_ok;
        accept          = in_valid[gnt_q] & beat_ok;
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = in_data[int'(gnt_q)*W +: W];
          out_last_d  = in_last[gnt_q];
          out_sel_d   = gnt_q;
          // Packet boundary: release the grant and advance the rotation pointer.
          if (in_last[gnt_q]) begin
            last_gnt_d = gnt_q;
            state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      last_gnt_q  <= SELW'(N - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_gnt_q  <= last_gnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_rr_stream.sv
// Directed self-checking bench for mux_rr_stream (N=4, W=8); override step needs MUX_SEL_OVERRIDE_EN.
module tb_mux_rr_stream;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int SELW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    in_valid;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_last;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic            out_last;
  logic [SELW-1:0] out_sel;
  logic            out_ready;
`ifdef MUX_SEL_OVERRIDE_EN
  logic            force_en;
  logic [SELW-1:0] force_sel;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  mux_rr_stream #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
`ifdef MUX_SEL_OVERRIDE_EN
    .force_en  (force_en),
    .force_sel (force_sel),
`endif
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [W-1:0] d, input logic lst);
    in_data[k*W +: W] = d;
    in_last[k]        = lst;
  endtask

  task automatic chk_beat(input string tag, input logic [SELW-1:0] sel,
                          input logic [W-1:0] d, input logic lst);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sel"},   32'(out_sel),   32'(sel));
    chk({tag, "_data"},  32'(out_data),  32'(d));
    chk({tag, "_last"},  32'(out_last),  32'(lst));
  endtask

  initial begin
    logic [SELW-1:0] rr_order [5];
    rr_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    in_last   = '0;
    out_ready = 1'b1;
`ifdef MUX_SEL_OVERRIDE_EN
    force_en  = 1'b0;
    force_sel = '0;
`endif
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_last",  32'(out_last),  32'd0);
    chk("rst_out_sel",   32'(out_sel),   32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    rst_n = 1'b1;

    // Single 3-beat packet on channel 1
    tick();
    in_valid = 4'b0010;
    set_ch(1, 8'hA1, 1'b0);
    #1 chk("pkt_idle_ready", 32'(in_ready), 32'd0);
    tick();
    chk("pkt_arb_valid", 32'(out_valid), 32'd0);
    chk("pkt_busy_ready", 32'(in_ready), 32'b0010);
    tick();
    chk_beat("pkt_a1", 2'd1, 8'hA1, 1'b0);
    set_ch(1, 8'hA2, 1'b0);
    tick();
    chk_beat("pkt_a2", 2'd1, 8'hA2, 1'b0);
    set_ch(1, 8'hA3, 1'b1);
    tick();
    chk_beat("pkt_a3", 2'd1, 8'hA3, 1'b1);
    in_valid = '0;
    in_last  = '0;
    tick();
    chk("pkt_drain_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-packet on channel 2
    in_valid = 4'b0100;
    set_ch(2, 8'hC1, 1'b0);
    tick();
    tick();
    chk_beat("rst2_c1", 2'd2, 8'hC1, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst2_out_valid", 32'(out_valid), 32'd0);
    chk("rst2_out_data",  32'(out_data),  32'd0);
    chk("rst2_out_sel",   32'(out_sel),   32'd0);
    chk("rst2_in_ready",  32'(in_ready),  32'd0);
    in_valid = '0;
    in_last  = '0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst2_no_leftover", 32'(out_valid), 32'd0);

    // Round robin over four always-valid channels, one-beat packets
    in_valid = 4'b1111;
    for (int k = 0; k < N; k++) set_ch(k, 8'(8'h30 + k), 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_beat($sformatf("rr%0d", i), rr_order[i], 8'(8'h30 + int'(rr_order[i])), 1'b1);
      if (i < 4) begin
        tick();
        chk($sformatf("rr_gap%0d", i), 32'(out_valid), 32'd0);
      end
    end
    in_valid = '0;
    in_last  = '0;
    tick();

    // Grant lock: channel 0 stalls mid-packet while channel 3 waits
    in_valid = 4'b0001;
    set_ch(0, 8'h40, 1'b0);
    tick();
    in_valid = 4'b1001;
    set_ch(3, 8'hD0, 1'b1);
    tick();
    chk_beat("lock_b0", 2'd0, 8'h40, 1'b0);
    in_valid = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("lock_hold_valid%0d", i), 32'(out_valid), 32'd0);
      chk($sformatf("lock_hold_ready%0d", i), 32'(in_ready), 32'b0001);
    end
    in_valid = 4'b1001;
    set_ch(0, 8'h41, 1'b1);
    tick();
    chk_beat("lock_b1", 2'd0, 8'h41, 1'b1);
    in_valid = 4'b1000;
    tick();
    chk("lock_arb_gap", 32'(out_valid), 32'd0);
    tick();
    chk_beat("lock_ch3", 2'd3, 8'hD0, 1'b1);
    in_valid = '0;
    in_last  = '0;
    tick();

    // Backpressure for five cycles in the middle of a channel 2 packet
    in_valid = 4'b0100;
    set_ch(2, 8'h51, 1'b0);
    tick();
    tick();
    chk_beat("bp_b0", 2'd2, 8'h51, 1'b0);
    out_ready = 1'b0;
    set_ch(2, 8'h52, 1'b1);
    #1 chk("bp_ready_low", 32'(in_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_beat($sformatf("bp_hold%0d", i), 2'd2, 8'h51, 1'b0);
      chk($sformatf("bp_hold_ready%0d", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1 chk("bp_ready_back", 32'(in_ready), 32'b0100);
    tick();
    chk_beat("bp_b1", 2'd2, 8'h52, 1'b1);
    in_valid = '0;
    in_last  = '0;
    tick();
    chk("bp_drain_valid", 32'(out_valid), 32'd0);

`ifdef MUX_SEL_OVERRIDE_EN
    // Forced grant to channel 3 with last grant on channel 0
    in_valid = 4'b0001;
    set_ch(0, 8'h60, 1'b1);
    tick();
    tick();
    chk_beat("ovr_ch0", 2'd0, 8'h60, 1'b1);
    in_valid = '0;
    tick();
    in_valid  = 4'b1010;
    set_ch(1, 8'h61, 1'b1);
    set_ch(3, 8'h63, 1'b1);
    force_en  = 1'b1;
    force_sel = 2'd3;
    tick();
    tick();
    chk_beat("ovr_forced", 2'd3, 8'h63, 1'b1);
    force_en = 1'b0;
    tick();
    tick();
    chk_beat("ovr_next", 2'd1, 8'h61, 1'b1);
    in_valid = '0;
    in_last  = '0;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
